// File: rtl/memory_responder_if.sv
// Initiator/responder bus for memory_responder; address width is `ARCH_SIZE (default 16).
// Write request signals exist only when MEM_WRITE_EN is defined.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

interface memory_responder_if;
    logic [`ARCH_SIZE-1:0] address;
    logic                  read;
    logic [7:0]            read_value;
    logic                  ready;
`ifdef MEM_WRITE_EN
    logic                  write;
    logic [7:0]            write_value;

    modport master (output address, read, write, write_value, input read_value, ready);
    modport slave  (input address, read, write, write_value, output read_value, ready);
`else
    modport master (output address, read, input read_value, ready);
    modport slave  (input address, read, output read_value, ready);
`endif
endinterface

// File: rtl/memory_responder.sv
// Four-phase handshake memory responder with fixed LATENCY from capture to ready.
// Optional write path compiled in with macro MEM_WRITE_EN.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

module memory_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic          clock,
    input logic          reset,
    memory_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [3:0]    counter;
    logic [AW-1:0] cap_addr;
    logic          ready_q;
    logic [7:0]    rv_q;
    logic          request;
    logic [7:0]    mem [DEPTH] = '{default: '0};
`ifdef MEM_WRITE_EN
    logic          cap_write;
    logic [7:0]    cap_data;
`endif

    // Upper address bits are deliberately ignored (wrap modulo DEPTH).
    logic unused_addr;
    assign unused_addr = ^bus.address;

    // The request level that keeps the captured transaction alive.
    always_comb begin
        request = bus.read;
`ifdef MEM_WRITE_EN
        if (cap_write) request = bus.write;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            rv_q    <= '0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read) begin
                        cap_addr  <= bus.address[AW-1:0];
                        counter   <= 4'(LATENCY - 1);
`ifdef MEM_WRITE_EN
                        cap_write <= 1'b0;
`endif
                        state     <= BUSY;
                    end
`ifdef MEM_WRITE_EN
                    else if (bus.write) begin
                        cap_addr  <= bus.address[AW-1:0];
                        cap_data  <= bus.write_value;
                        counter   <= 4'(LATENCY - 1);
                        cap_write <= 1'b1;
                        state     <= BUSY;
                    end
`endif
                end
                BUSY: begin
                    if (!request) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else if (counter == 4'd0) begin
`ifdef MEM_WRITE_EN
                        if (cap_write) mem[cap_addr] <= cap_data;
                        else           rv_q <= mem[cap_addr];
`else
                        rv_q <= mem[cap_addr];
`endif
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    if (!request) begin
                        ready_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.read_value = rv_q;
endmodule
